// File: rtl/axi4_lite_read_arbiter.sv
// Purpose : round-robin share of one AXI4-Lite read master between NUM_REQ requesters.
// Latency : accept at T, mst_read_start at T+1, rsp_valid at T+4 plus slave wait states.
// Backpr. : one transaction in flight; requests wait (req_valid held) until IDLE and master idle.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req_valid/addr    per-requester request and packed address (i at [i*ADDR_WIDTH +: ADDR_WIDTH])
//   req_ready         one-hot, one-cycle acceptance pulse
//   rsp_valid/data    one-hot, one-cycle completion pulse; data broadcast from the master
//   arb_busy          high whenever the FSM is not IDLE
//   mst_read_*        command/status interface of the read master
module axi4_lite_read_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          arb_busy,
  output logic                          mst_read_start,
  output logic [ADDR_WIDTH-1:0]         mst_read_addr,
  input  logic                          mst_read_busy,
  input  logic [DATA_WIDTH-1:0]         mst_read_data
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, ACTIVE} state_t;

  state_t           state;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] cand;
  logic             found;
  logic             accept;
  int               cand_int;

  // Round-robin search starting one past the last grant. The modulo keeps the
  // wrap correct when NUM_REQ is not a power of two.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    cand     = '0;
    cand_int = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_int = (int'(last_grant) + k) % NUM_REQ;
      cand     = IDX_W'(cand_int);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign accept    = (state == IDLE) && !mst_read_busy && found;
  assign req_ready = accept ? (NUM_REQ'(1) << winner) : '0;

  // The master deasserts busy only after registering read_data, so the word is
  // already valid in the completion cycle.
  assign rsp_valid = ((state == ACTIVE) && !mst_read_busy) ? (NUM_REQ'(1) << grant_idx) : '0;
  assign rsp_data  = mst_read_data;
  assign arb_busy  = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      grant_idx      <= '0;
      last_grant     <= IDX_W'(NUM_REQ - 1);
      mst_read_addr  <= '0;
      mst_read_start <= 1'b0;
    end else begin
      mst_read_start <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            grant_idx      <= winner;
            last_grant     <= winner;
            mst_read_addr  <= req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
            mst_read_start <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          // Master raises busy off this start pulse, so busy is valid in ACTIVE.
          state <= ACTIVE;
        end
        ACTIVE: begin
          if (!mst_read_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_read_arbiter.sv
module tb_axi4_lite_read_arbiter;

  logic        clk;
  logic        rst;
  logic        force_busy;
  int          ar_wait;
  int          r_wait;
  int          vectors;
  int          miscompares;
  int          lg [2];
  logic [31:0] addr_tbl [2][3];

  // Instance A: two requesters
  logic [1:0]  rv_a;
  logic [63:0] req_addr_a;
  logic [1:0]  ready_a, rsp_a;
  logic [31:0] rdata_a, maddr_a, mdata_a;
  logic        abusy_a, start_a, mbusy_a;

  // Instance B: three requesters (non-power-of-2 wrap)
  logic [2:0]  rv_b;
  logic [95:0] req_addr_b;
  logic [2:0]  ready_b, rsp_b;
  logic [31:0] rdata_b, maddr_b, mdata_b;
  logic        abusy_b, start_b, mbusy_b;

  // Read master model: busy rises the cycle after read_start and stays high
  // for 2 + wait-state cycles; data is registered as busy falls.
  logic        m_busy [2];
  logic [31:0] m_data [2];
  logic [31:0] m_addr [2];
  int          m_cnt  [2];
  logic [1:0]  start_v;
  logic [31:0] maddr_v [2];

  assign req_addr_a = {addr_tbl[0][1], addr_tbl[0][0]};
  assign req_addr_b = {addr_tbl[1][2], addr_tbl[1][1], addr_tbl[1][0]};
  assign start_v    = {start_b, start_a};
  assign maddr_v[0] = maddr_a;
  assign maddr_v[1] = maddr_b;
  assign mbusy_a    = m_busy[0] | force_busy;
  assign mbusy_b    = m_busy[1];
  assign mdata_a    = m_data[0];
  assign mdata_b    = m_data[1];

  axi4_lite_read_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut_a (
    .clk(clk), .rst(rst), .req_valid(rv_a), .req_addr(req_addr_a), .req_ready(ready_a),
    .rsp_valid(rsp_a), .rsp_data(rdata_a), .arb_busy(abusy_a), .mst_read_start(start_a),
    .mst_read_addr(maddr_a), .mst_read_busy(mbusy_a), .mst_read_data(mdata_a)
  );

  axi4_lite_read_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut_b (
    .clk(clk), .rst(rst), .req_valid(rv_b), .req_addr(req_addr_b), .req_ready(ready_b),
    .rsp_valid(rsp_b), .rsp_data(rdata_b), .arb_busy(abusy_b), .mst_read_start(start_b),
    .mst_read_addr(maddr_b), .mst_read_busy(mbusy_b), .mst_read_data(mdata_b)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] slave_word(input logic [31:0] a);
    if (a == 32'h0000_1000) return 32'hDEAD_BEEF;
    return (a * 32'h0000_9E37) ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] <= 1'b0;
        m_data[i] <= '0;
        m_addr[i] <= '0;
        m_cnt[i]  <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!m_busy[i]) begin
          if (start_v[i]) begin
            m_busy[i] <= 1'b1;
            m_cnt[i]  <= 1 + ar_wait + r_wait;
            m_addr[i] <= maddr_v[i];
          end
        end else if (m_cnt[i] == 0) begin
          m_busy[i] <= 1'b0;
          m_data[i] <= slave_word(m_addr[i]);
        end else begin
          m_cnt[i] <= m_cnt[i] - 1;
        end
      end
    end
  end

  // Reference arbitration: first pending requester after the last grant, wrapping.
  function automatic int rr_pick(input int last, input int n, input logic [2:0] mask);
    for (int k = 1; k <= n; k++) begin
      if (mask[(last + k) % n]) return (last + k) % n;
    end
    return -1;
  endfunction

  function automatic logic [2:0] f_rv(input int inst);
    return (inst != 0) ? rv_b : {1'b0, rv_a};
  endfunction
  function automatic logic [2:0] f_ready(input int inst);
    return (inst != 0) ? ready_b : {1'b0, ready_a};
  endfunction
  function automatic logic [2:0] f_rsp(input int inst);
    return (inst != 0) ? rsp_b : {1'b0, rsp_a};
  endfunction
  function automatic logic f_abusy(input int inst);
    return (inst != 0) ? abusy_b : abusy_a;
  endfunction
  function automatic logic f_start(input int inst);
    return (inst != 0) ? start_b : start_a;
  endfunction
  function automatic logic [31:0] f_maddr(input int inst);
    return (inst != 0) ? maddr_b : maddr_a;
  endfunction
  function automatic logic [31:0] f_rdata(input int inst);
    return (inst != 0) ? rdata_b : rdata_a;
  endfunction

  task automatic set_rv(input int inst, input logic [2:0] v);
    if (inst != 0) rv_b = v;
    else rv_a = v[1:0];
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One full transaction starting in an IDLE cycle (called at posedge+1).
  task automatic transact(input int inst, input int arw, input int rw, input bit hold_all);
    int          n, w, lat, starts;
    logic [2:0]  mask;
    logic [31:0] a;
    n    = (inst != 0) ? 3 : 2;
    mask = f_rv(inst);
    w    = rr_pick(lg[inst], n, mask);
    if (w < 0) w = 0;
    a       = addr_tbl[inst][w];
    ar_wait = arw;
    r_wait  = rw;
    @(negedge clk);
    chk("idle_arb_busy", 64'(f_abusy(inst)), 64'd0);
    chk("idle_rsp_valid", 64'(f_rsp(inst)), 64'd0);
    chk("req_ready", 64'(f_ready(inst)), 64'd1 << w);
    @(posedge clk); #1;
    lg[inst] = w;
    set_rv(inst, hold_all ? mask : (mask & ~(3'b001 << w)));
    @(negedge clk);
    chk("read_start", 64'(f_start(inst)), 64'd1);
    chk("read_addr", 64'(f_maddr(inst)), 64'(a));
    chk("ready_after_accept", 64'(f_ready(inst)), 64'd0);
    chk("arb_busy", 64'(f_abusy(inst)), 64'd1);
    lat    = 1;
    starts = 1;
    while (f_rsp(inst) == 3'b000 && lat < 64) begin
      @(posedge clk); #1;
      @(negedge clk);
      lat++;
      if (f_start(inst)) starts++;
    end
    chk("latency", 64'(lat), 64'(4 + arw + rw));
    chk("start_pulses", 64'(starts), 64'd1);
    chk("rsp_valid", 64'(f_rsp(inst)), 64'd1 << w);
    chk("rsp_data", 64'(f_rdata(inst)), 64'(slave_word(a)));
    chk("addr_held", 64'(f_maddr(inst)), 64'(a));
    @(posedge clk); #1;
  endtask

  initial begin
    int          n;
    logic [2:0]  cur, nb;
    clk = 1'b0; rst = 1'b1; force_busy = 1'b0;
    ar_wait = 0; r_wait = 0; vectors = 0; miscompares = 0;
    lg[0] = 1; lg[1] = 2;
    rv_a = '0; rv_b = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 3; j++) addr_tbl[i][j] = '0;

    // Reset values
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_req_ready", 64'(ready_a), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_a), 64'd0);
    chk("rst_arb_busy", 64'(abusy_a), 64'd0);
    chk("rst_read_start", 64'(start_a), 64'd0);
    chk("rst_read_addr", 64'(maddr_a), 64'd0);
    chk("rst_rsp_data", 64'(rdata_a), 64'd0);
    chk("rst_b_busy", 64'(abusy_b), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single request, no wait states
    addr_tbl[0][0] = 32'h0000_1000;
    addr_tbl[0][1] = 32'h0000_2000;
    rv_a = 2'b01;
    transact(0, 0, 0, 1'b0);

    // Wait states: ARREADY +3, RVALID +2
    rv_a = 2'b01;
    transact(0, 3, 2, 1'b0);

    // Master busy while IDLE: nothing accepted until busy drops
    force_busy = 1'b1;
    rv_a = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("busy_no_accept", 64'(ready_a), 64'd0);
      @(posedge clk); #1;
    end
    force_busy = 1'b0;
    transact(0, 0, 0, 1'b0);

    // Reset two cycles after read_start: transaction abandoned
    rv_a = 2'b01;
    ar_wait = 5; r_wait = 0;
    @(negedge clk);
    chk("pre_rst_accept", 64'(ready_a), 64'd1);
    @(posedge clk); #1;
    rv_a = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    lg[0] = 1; lg[1] = 2;
    @(negedge clk);
    chk("midrst_arb_busy", 64'(abusy_a), 64'd0);
    chk("midrst_read_addr", 64'(maddr_a), 64'd0);
    chk("midrst_read_start", 64'(start_a), 64'd0);
    chk("midrst_rsp_valid", 64'(rsp_a), 64'd0);
    chk("midrst_rsp_data", 64'(rdata_a), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", 64'(rsp_a), 64'd0);
      @(posedge clk); #1;
    end

    // Contention after reset: requester 0 first, then alternate
    addr_tbl[0][0] = 32'h0000_0100;
    addr_tbl[0][1] = 32'h0000_0200;
    rv_a = 2'b11;
    for (int i = 0; i < 4; i++) transact(0, 0, 0, i < 3);
    while (rv_a != 2'b00) transact(0, 0, 0, 1'b0);

    // Three requesters: order 0,1,2,0 and wrap from 2 to 0
    addr_tbl[1][0] = 32'h0000_0300;
    addr_tbl[1][1] = 32'h0000_0400;
    addr_tbl[1][2] = 32'h0000_0500;
    rv_b = 3'b111;
    for (int i = 0; i < 4; i++) transact(1, i, 0, i < 3);
    while (rv_b != 3'b000) transact(1, 0, 0, 1'b0);

    // Randomized traffic on both instances
    for (int inst = 0; inst < 2; inst++) begin
      n = (inst != 0) ? 3 : 2;
      for (int t = 0; t < 12; t++) begin
        cur = f_rv(inst);
        nb  = 3'($urandom_range(0, (1 << n) - 1)) & ~cur;
        if ((cur | nb) == 3'b000) nb = 3'b001;
        for (int i = 0; i < n; i++)
          if (nb[i]) addr_tbl[inst][i] = $urandom & 32'hFFFF_FFFC;
        set_rv(inst, cur | nb);
        transact(inst, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
      end
      while (f_rv(inst) != 3'b000) transact(inst, 0, 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi4_lite_read_arbiter.md
# axi4_lite_read_arbiter

Round-robin arbiter that shares one `axi4_lite_read_master` between `NUM_REQ` requesters, for example instruction fetch and data load in the RISC-V core.
- Accepts one request at a time through a valid/ready handshake.
- Sequences the master's `read_start`/`read_addr` command interface.
- Tracks completion through the master's `read_busy`.
- Returns the read word to the granted requester with a one-cycle response pulse.
- Sits between the core memory ports and the read master, with no AXI signals of its own.

## Interface
- `NUM_REQ`, 2: number of requesters, range 2..8.
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width.
- Clocking and reset (already decided): one clock; reset is asynchronous and active-high.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  request pending, one bit per requester; held until accepted.
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  packed request addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]; held stable while `req_valid[i]`.
- `req_ready`  out  NUM_REQ  one-hot acceptance pulse, one cycle.
- `rsp_valid`  out  NUM_REQ  one-hot read-complete pulse, one cycle.
- `rsp_data`  out  DATA_WIDTH  read word, broadcast to all requesters; meaningful only while `rsp_valid` is nonzero.
- `arb_busy`  out  1  a transaction is in flight (any state other than IDLE).
- `mst_read_start`  out  1  drives the master's `read_start`; one-cycle pulse.
- `mst_read_addr`  out  ADDR_WIDTH  drives the master's `read_addr`.
- `mst_read_busy`  in  1  from the master's `read_busy`.
- `mst_read_data`  in  DATA_WIDTH  from the master's `read_data`.

## Operation
- FSM states: IDLE, ISSUE, ACTIVE.
- **IDLE**
  - If `mst_read_busy`==0 and `req_valid` is nonzero, pick the winner by round-robin.
  - Assert `req_ready[winner]` combinationally in the same cycle.
  - Register `grant_idx` = winner, `mst_read_addr` = `req_addr[winner]`, `last_grant` = winner.
  - Go to ISSUE.
  - If `mst_read_busy`==1, accept nothing and stay in IDLE.
- **Round-robin**
  - Search starts at index `last_grant`+1 and wraps modulo NUM_REQ; first set bit wins.
  - `last_grant` resets to NUM_REQ-1, so requester 0 has top priority after reset.
- **ISSUE**
  - `mst_read_start`=1 for exactly this cycle; go to ACTIVE unconditionally.
- **ACTIVE**
  - Wait while `mst_read_busy`==1.
  - On the first cycle with `mst_read_busy`==0: `rsp_valid[grant_idx]`=1 and `rsp_data` = `mst_read_data`, which the master has already registered; go to IDLE.
  - ACTIVE is entered one cycle after `read_start`. The master has raised `read_busy` by then, so a 0 seen in ACTIVE always means completion.
- **Outputs by state**
  - `rsp_data` is combinationally equal to `mst_read_data` at all times.
  - `req_ready` and `rsp_valid` are 0 outside the cycles named above.
  - `mst_read_addr` holds its value after ISSUE and changes only on acceptance.
- **Requests**
  - One outstanding transaction at most; no pipelining.
  - A requester may raise `req_valid` again in the cycle of its own `rsp_valid`.
  - `req_valid` deasserted before acceptance is a protocol violation; behaviour is unspecified.
- **Width**
  - `grant_idx` and `last_grant` are $clog2(NUM_REQ) bits.
  - Wrap arithmetic must be correct for non-power-of-2 NUM_REQ (e.g. 3): index NUM_REQ-1 wraps to 0.

## Timing
- **Reset values:**
  - State IDLE, `last_grant` = NUM_REQ-1.
  - `mst_read_addr` = 0, `mst_read_start` = 0.
  - `req_ready` = 0, `rsp_valid` = 0, `arb_busy` = 0.
  - `rsp_data` follows `mst_read_data`, which is 0 in master reset.
- **Nominal sequence:**
  - Accept at T (IDLE).
  - `mst_read_start` at T+1.
  - Master in address phase at T+2.
  - With ARREADY at T+2 and RVALID at T+3, master busy drops at T+4, so `rsp_valid` at T+4.
  - IDLE at T+5, next accept at T+5 at the earliest.
- **Request-to-response latency:** 4 cycles plus slave wait states (each cycle ARREADY or RVALID is delayed adds one).
- **Simultaneous requests:** the loser stays pending and is granted at the next IDLE, so no requester starves. Worst-case wait is NUM_REQ-1 transactions.
- **Reset mid-operation:** the in-flight transaction is abandoned and no `rsp_valid` is issued. The master shares `rst` and is reset with it.

## Test plan
- **Single request:** req_valid=01, addr0=0x0000_1000; slave returns 0xDEADBEEF with ARREADY and RVALID after 0 waits.
  - req_ready=01 at T, mst_read_start at T+1 with addr 0x1000.
  - rsp_valid=01 with rsp_data=0xDEADBEEF at T+4.
- **Contention:** req_valid=11 held, addr0=0x100, addr1=0x200, four back-to-back transactions.
  - Grant order 0,1,0,1.
  - mst_read_addr sequence 0x100, 0x200, 0x100, 0x200.
- **Wait states:** ARREADY delayed 3 cycles, RVALID delayed 2 cycles.
  - rsp_valid 5 cycles later than the single-request case, exactly one pulse.
  - mst_read_start pulsed once.
- **Master busy at idle:** force mst_read_busy=1 with req_valid=01.
  - No req_ready while busy=1; acceptance in the first cycle busy=0.
- **Reset in ACTIVE:** assert rst two cycles after mst_read_start.
  - All outputs return to reset values, and no rsp_valid appears.
  - After release, req_valid=11 grants requester 0 first.
- **NUM_REQ=3 wrap:** req_valid=111 held.
  - Grant order 0,1,2,0 with correct addresses.
  - rsp_valid is one-hot each time.
